// File: rtl/gate_exerciser.sv
// gate_exerciser
//   Automatic stimulus and checker for a two-input configurable gate
//   (sel=0 -> y=a&b, sel=1 -> y=a|b). A scan applies every {sel,a,b}
//   vector in order and holds each one for SETTLE_CYCLES cycles. It then
//   samples y_i into an 8-bit truth table and compares the table with
//   EXPECT.
//
//   Optional feature macro: GATE_EXER_STEP_EN. When it is defined, the
//   step_i port exists. Each vector then leaves SETTLE only on a step_i
//   pulse that arrives after the settle count has expired. This suits a
//   push-button on the board.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (1..255)
//   EXPECT         expected truth table, bit index {sel,a,b}
//
// Ports
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   start     one-cycle scan request, honoured in IDLE or DONE
//   sel_o     select driven to the gate under test
//   a_o, b_o  operands driven to the gate under test
//   y_i       gate output, sampled after the settle time
//   step_i    manual advance pulse (GATE_EXER_STEP_EN only)
//   busy      scan in progress
//   done      scan complete; table_o/pass/fail_idx valid
//   table_o   captured truth table
//   pass      table_o == EXPECT
//   fail_idx  lowest mismatching index, 0 when pass
module gate_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECT        = 8'hE8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       sel_o,
  output logic       a_o,
  output logic       b_o,
  input  logic       y_i,
`ifdef GATE_EXER_STEP_EN
  input  logic       step_i,
`endif
  output logic       busy,
  output logic       done,
  output logic [7:0] table_o,
  output logic       pass,
  output logic [2:0] fail_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state, state_next;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic       settle_done;
  logic [7:0] table_sampled;
  logic [7:0] mismatch;
  logic [2:0] fail_lowest;

  // idx is 0 in IDLE, so the drives are 0 there as well.
  assign {sel_o, a_o, b_o} = idx;

`ifdef GATE_EXER_STEP_EN
  // A step pulse before expiry has no effect, so it is dropped rather than queued.
  assign settle_done = (cnt == SETTLE_LAST) && step_i;
`else
  assign settle_done = (cnt == SETTLE_LAST);
`endif

  // The table as it will look after the current sample. The final result
  // is computed from this so that it includes the last vector.
  always_comb begin
    // NOTE: defaults come first so that no path leaves a variable unassigned, which would infer a latch.
    table_sampled      = table_o;
    table_sampled[idx] = y_i;
    mismatch           = table_sampled ^ EXPECT;
    fail_lowest        = 3'd0;
    // Scan downward so that the lowest mismatching index is the one kept.
    for (int i = 7; i >= 0; i--) begin
      if (mismatch[i]) fail_lowest = 3'(i);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start)       state_next = SETTLE;
      SETTLE:     if (settle_done) state_next = SAMPLE;
      SAMPLE:     state_next = (idx == 3'd7) ? DONE : SETTLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: every register, the truth table included, is reset so that a mid-scan reset discards partial results.
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= 8'd0;
      table_o  <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail_idx <= 3'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register updates from pre-edge values.
      state <= state_next;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx      <= 3'd0;
            cnt      <= 8'd0;
            table_o  <= 8'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail_idx <= 3'd0;
          end
        end
        SETTLE: begin
          // Hold at the last value once the count expires. In step mode the
          // count then stays "expired" until step_i arrives.
          if (cnt != SETTLE_LAST) cnt <= cnt + 8'd1;
        end
        SAMPLE: begin
          table_o <= table_sampled;
          if (idx != 3'd7) begin
            idx <= idx + 3'd1;
            cnt <= 8'd0;
          end else begin
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (mismatch == 8'd0);
            fail_idx <= fail_lowest;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed testbench for gate_exerciser. A small gate model with selectable
// faults feeds y_i. Each task drives one scenario and checks its results inline.
module tb_gate_exerciser;

`ifdef GATE_EXER_STEP_EN
  localparam int SETTLE = 2;
`else
  localparam int SETTLE = 4;
`endif
  localparam int VEC  = SETTLE + 1;
  localparam int SCAN = 8 * VEC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       step_i = 1'b0;
  logic       sel_o, a_o, b_o, y_i;
  logic       busy, done, pass;
  logic [7:0] table_o;
  logic [2:0] fail_idx;

  int tests_run = 0;
  int tests_failed = 0;
  int gate_mode = 0;  // 0 correct gate, 1 output stuck at 0, 2 ignores sel (always AND)

  always #5 clk = ~clk;

  always_comb begin
    case (gate_mode)
      1:       y_i = 1'b0;
      2:       y_i = a_o & b_o;
      default: y_i = sel_o ? (a_o | b_o) : (a_o & b_o);
    endcase
  end

  gate_exerciser #(.SETTLE_CYCLES(SETTLE), .EXPECT(8'hE8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sel_o    (sel_o),
    .a_o      (a_o),
    .b_o      (b_o),
    .y_i      (y_i),
`ifdef GATE_EXER_STEP_EN
    .step_i   (step_i),
`endif
    .busy     (busy),
    .done     (done),
    .table_o  (table_o),
    .pass     (pass),
    .fail_idx (fail_idx)
  );

  // Compares every output with the all-zero reset/idle state.
  task automatic check_idle(input string name);
    tests_run++;
    if ({busy, done, pass, fail_idx, table_o, sel_o, a_o, b_o} !== 17'd0) begin
      tests_failed++;
      $display("FAIL %s: busy=%b done=%b pass=%b fail_idx=%0d table=%h drv=%b%b%b, all 0 required",
               name, busy, done, pass, fail_idx, table_o, sel_o, a_o, b_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("idle_after_reset");
  endtask

  // Pulses start, follows the scan cycle by cycle and checks the results.
  // poke_at >= 0 raises start again at that cycle of the scan.
  task automatic run_scan(input string name, input logic [7:0] exp_tab, input logic exp_pass,
                          input logic [2:0] exp_fidx, input int poke_at);
    int seq_err = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_start: busy=%b done=%b, busy=1 done=0 required", name, busy, done);
    end
    for (int c = 0; c <= SCAN; c++) begin
      if (c > 0) @(negedge clk);
      start = (c == poke_at);
      if (c < SCAN) begin
        if ({sel_o, a_o, b_o} !== 3'(c / VEC)) seq_err++;
        if (done !== 1'b0 || busy !== 1'b1) seq_err++;
      end
    end
    start = 1'b0;
    tests_run++;
    if (seq_err != 0) begin
      tests_failed++;
      $display("FAIL %s_sequence: %0d bad cycles, 0 required", name, seq_err);
    end
    tests_run++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_done: done=%b busy=%b at cycle %0d, done=1 busy=0 required", name, done, busy, SCAN);
    end
    tests_run++;
    if (table_o !== exp_tab) begin
      tests_failed++;
      $display("FAIL %s_table: got %h, %h required", name, table_o, exp_tab);
    end
    tests_run++;
    if (pass !== exp_pass || fail_idx !== exp_fidx) begin
      tests_failed++;
      $display("FAIL %s_verdict: pass=%b fail_idx=%0d, pass=%b fail_idx=%0d required",
               name, pass, fail_idx, exp_pass, exp_fidx);
    end
  endtask

  task automatic test_gate_models();
    gate_mode = 0;
    run_scan("correct", 8'hE8, 1'b1, 3'd0, -1);
    gate_mode = 1;
    run_scan("stuck0", 8'h00, 1'b0, 3'd3, -1);
    gate_mode = 2;
    run_scan("always_and", 8'h88, 1'b0, 3'd5, -1);
    gate_mode = 0;
  endtask

  task automatic test_back_to_back();
    // A start during a scan is ignored; a start in DONE restarts immediately.
    run_scan("start_ignored", 8'hE8, 1'b1, 3'd0, 10);
    run_scan("restart_from_done", 8'hE8, 1'b1, 3'd0, -1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check_idle("mid_scan_reset");
    repeat (4) @(negedge clk);
    check_idle("stays_idle");
    run_scan("after_reset", 8'hE8, 1'b1, 3'd0, -1);
  endtask

  task automatic test_step();
    int hold_err = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) begin start = 1'b0; step_i = 1'b1; end  // this pulse lands at cnt=0
    @(negedge clk) step_i = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if ({sel_o, a_o, b_o} !== 3'd0 || busy !== 1'b1) hold_err++;
    end
    tests_run++;
    if (hold_err != 0) begin
      tests_failed++;
      $display("FAIL step_hold: %0d cycles advanced or idle, 0 required", hold_err);
    end
    for (int v = 0; v < 8; v++) begin
      @(negedge clk) step_i = 1'b1;
      @(negedge clk) step_i = 1'b0;
      repeat (3) @(negedge clk);
    end
    tests_run++;
    if (done !== 1'b1 || table_o !== 8'hE8 || pass !== 1'b1) begin
      tests_failed++;
      $display("FAIL step_scan: done=%b table=%h pass=%b, done=1 table=e8 pass=1 required",
               done, table_o, pass);
    end
  endtask

  initial begin
    test_reset();
`ifdef GATE_EXER_STEP_EN
    test_step();
`else
    test_gate_models();
    test_back_to_back();
    test_mid_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
